c7b_ifu_fetch: RTL and testbench
================================

// Module: c7b_ifu_fetch
// PURPOSE
//  Instruction fetch front-end directly upstream of the c7bicu instruction cache. It generates the fetch PC and issues
//  8-byte-aligned ic1 requests. It takes the 64-bit ic2 response, splits it into two 32-bit instructions with their PCs,
//  and buffers them in a small queue drained by decode over a valid/ready handshake. Redirects flush the queue and kill
//  any in-flight response.
// PARAMETERS
//  RESET_PC   32'h0000_0000  fetch PC after reset; bits [1:0] must be 0
//  QDEPTH     4              instruction queue entries (power of 2, >= 2)
// PORTS
//  clk                     in   1   clock; all state updates on rising edge
//  reset                   in   1   synchronous reset, active-high
//  redirect_valid          in   1   branch/exception redirect, one-cycle pulse
//  redirect_pc             in   30  new fetch PC [31:2]
//  ifu_icu_req_ic1         out  1   fetch request to ICU
//  ifu_icu_addr_ic1        out  29  fetch address [31:3]
//  icu_ifu_ack_ic1         in   1   request accepted this cycle (same-cycle as req)
//  icu_ifu_data_valid_ic2  in   1   response data valid
//  icu_ifu_data_ic2        in   64  [31:0] = inst at addr+0, [63:32] = inst at addr+4
//  ifu_de_valid            out  1   queue head valid
//  ifu_de_inst             out  32  queue head instruction
//  ifu_de_pc               out  32  queue head PC
//  de_ifu_ready            in   1   decode pops head when valid & ready
// BEHAVIOUR
//  Reset: state=IDLE, drop=0, fetch_pc=RESET_PC, queue count=0; req=0, de_valid=0, inst/pc outputs 0.
//  FSM, two states:
//   IDLE: req = (QDEPTH-count >= 2) & ~redirect_valid; addr = fetch_pc[31:3]
//   IDLE -> WAIT on req&ack: req_pc <= fetch_pc; fetch_pc <= {fetch_pc[31:3]+1, 3'b0}
//   WAIT: req=0; on data_valid -> IDLE, push response unless drop; clear drop
//  Request rules:
//   req/addr recomputed each cycle; an un-acked req has no side effect
//   at most one request outstanding
//   the space check uses the registered count only, not same-cycle pops
//  Push on response:
//   req_pc[2]==0: push {data[31:0], req_pc}, then {data[63:32], req_pc+4}; two entries in one cycle
//   req_pc[2]==1: push only {data[63:32], req_pc}
//   space for 2 is guaranteed by the issue check
//  Queue: de_valid = (count!=0). Pop and push may occur in the same cycle; count += pushes - pop.
//   Pointers wrap modulo QDEPTH.
//  Redirect (priority over everything else):
//   count <= 0; fetch_pc <= {redirect_pc, 2'b00}
//   in WAIT, or IDLE with ack this cycle: enter/stay WAIT with drop=1
//   data_valid in the same cycle as redirect is discarded
//   de_valid is 0 the cycle after redirect; the pop in the redirect cycle is honoured
//  PC wrap: line 32'hFFFF_FFF8 + 8 -> 32'h0000_0000; no fault.
//  data_valid while IDLE is illegal: ignore it and flag a simulation assertion.
//  Latency, cache hit: req/ack in cycle N, data in N+1, de_valid in N+2. Steady-state throughput: 2 inst per 2 cycles.
// STRUCTURE
//  Package c7b_ifu_pkg:
//   fetch_state_t {IDLE, WAIT}
//   INST_W=32, PC_W=32, LINE_OFF=3
//   ibuf entry typedef {inst, pc}
//  Sub-module c7b_ifu_ibuf: dual-push / single-pop FIFO with QDEPTH entries, count, and flush input.
//  The top holds the FSM, fetch_pc, req_pc, drop, and the push split.
// TESTING
//  1 Reset then ack every req, data next cycle, ready=1, ICU data = address pattern:
//    insts at pc 0,4,8,C... in order; first de_valid 2 cycles after first ack.
//  2 ready=0 with continuous hits: exactly 4 entries fill; req stays 0 while count>2; ready=1 resumes in order.
//  3 redirect_pc = 0x104>>2 while IDLE: addr=0x104>>3; only inst at 0x104 pushed, then 0x108 line.
//  4 redirect during WAIT; miss data arrives 5 cycles later: data dropped, queue empty;
//    next req addr = redirect line; no stale inst reaches decode.
//  5 redirect in the same cycle as data_valid and pop: data discarded, count=0 next cycle, fetch from new PC.
//  6 RESET_PC=32'hFFFF_FFF8: pcs FFFF_FFF8, FFFF_FFFC, 0, 4; reset asserted in WAIT returns req=0, count=0.

Source files
------------

// File: rtl/c7b_ifu_pkg.sv
// Shared types and constants for the c7b instruction fetch unit.
package c7b_ifu_pkg;

  localparam int INST_W   = 32;
  localparam int PC_W     = 32;
  localparam int LINE_OFF = 3;

  // Fetch FSM: IDLE may issue a request, WAIT holds one outstanding request.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_t;

  // One instruction buffer slot.
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } ibuf_entry_t;

endpackage

// File: rtl/c7b_ifu_ibuf.sv
// Instruction buffer: dual-push / single-pop FIFO with synchronous flush.
// push1 is only ever used together with push0; entry1 lands behind entry0.
// Handshake: head is offered while head_valid=1; it is consumed on a cycle
// where head_valid & pop are both high, and never changes otherwise.
module c7b_ifu_ibuf
  import c7b_ifu_pkg::*;
#(
  parameter int QDEPTH = 4,
  localparam int PTR_W = $clog2(QDEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push0,
  input  ibuf_entry_t      entry0,
  input  logic             push1,
  input  ibuf_entry_t      entry1,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic             head_valid,
  output ibuf_entry_t      head
);

  ibuf_entry_t      mem [QDEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign head_valid = (count != '0);
  assign head       = mem[rd_ptr];
  assign do_pop     = pop && head_valid;

  // Storage writes; the issue logic guarantees room for both entries.
  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr] <= entry0;
    if (push1) mem[wr_ptr + PTR_W'(1)] <= entry1;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at QDEPTH.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push0) + PTR_W'(push1);
      rd_ptr <= rd_ptr + PTR_W'(do_pop);
      count  <= count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/c7b_ifu_fetch.sv
// Fetch front-end: generates line-aligned ICU requests, splits each 64-bit
// response into two instructions and queues them for decode.
// Decode handshake: ifu_de_valid/inst/pc describe the queue head; the head
// is popped on any cycle where ifu_de_valid & de_ifu_ready are both high.
module c7b_ifu_fetch
  import c7b_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [29:0] redirect_pc,
  output logic        ifu_icu_req_ic1,
  output logic [28:0] ifu_icu_addr_ic1,
  input  logic        icu_ifu_ack_ic1,
  input  logic        icu_ifu_data_valid_ic2,
  input  logic [63:0] icu_ifu_data_ic2,
  output logic        ifu_de_valid,
  output logic [31:0] ifu_de_inst,
  output logic [31:0] ifu_de_pc,
  input  logic        de_ifu_ready
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;

  fetch_state_t    state;
  logic            drop;
  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] req_pc;
  logic [CNT_W-1:0] count;
  logic            space_ok;
  logic            req;
  logic            fire;
  logic            rsp;
  logic            push0;
  logic            push1;
  ibuf_entry_t     entry0;
  ibuf_entry_t     entry1;
  ibuf_entry_t     head;
  logic            head_valid;

  // Issue only when a full line (two slots) fits, judged on the registered count.
  assign space_ok         = (CNT_W'(QDEPTH) - count) >= CNT_W'(2);
  assign req              = !reset && (state == IDLE) && space_ok && !redirect_valid;
  assign ifu_icu_req_ic1  = req;
  assign ifu_icu_addr_ic1 = fetch_pc[PC_W-1:LINE_OFF];
  assign fire             = req && icu_ifu_ack_ic1;
  assign rsp              = (state == WAIT) && icu_ifu_data_valid_ic2;

  // A response is queued unless it belongs to a request killed by a redirect.
  assign push0       = rsp && !drop && !redirect_valid;
  assign push1       = push0 && !req_pc[2];
  assign entry0.inst = req_pc[2] ? icu_ifu_data_ic2[63:32] : icu_ifu_data_ic2[31:0];
  assign entry0.pc   = req_pc;
  assign entry1.inst = icu_ifu_data_ic2[63:32];
  assign entry1.pc   = {req_pc[PC_W-1:LINE_OFF], 3'b100};

  // Fetch FSM with fetch/request PCs and the drop flag for killed responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      drop     <= 1'b0;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc, 2'b00};
      if (rsp) begin
        // The awaited response arrived with the redirect: discard it and refetch.
        state <= IDLE;
        drop  <= 1'b0;
      end else if (state == WAIT || icu_ifu_ack_ic1) begin
        state <= WAIT;
        drop  <= 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          if (fire) begin
            state    <= WAIT;
            req_pc   <= fetch_pc;
            fetch_pc <= {fetch_pc[PC_W-1:LINE_OFF], 3'b000} + PC_W'(8);
          end
        end
        WAIT: begin
          if (icu_ifu_data_valid_ic2) begin
            state <= IDLE;
            drop  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  c7b_ifu_ibuf #(.QDEPTH(QDEPTH)) u_ibuf (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push0      (push0),
    .entry0     (entry0),
    .push1      (push1),
    .entry1     (entry1),
    .pop        (de_ifu_ready),
    .count      (count),
    .head_valid (head_valid),
    .head       (head)
  );

  assign ifu_de_valid = head_valid;
  assign ifu_de_inst  = head_valid ? head.inst : '0;
  assign ifu_de_pc    = head_valid ? head.pc   : '0;

  // Responses are only legal while a request is outstanding.
  assert property (@(posedge clk) disable iff (reset)
                   !(state == IDLE && icu_ifu_data_valid_ic2))
    else $error("c7b_ifu_fetch: data_valid while IDLE");

endmodule

// File: tb/tb_c7b_ifu_fetch.sv
// Bench for c7b_ifu_fetch: directed table, hand sequences and random traffic
// checked against a queue-based model of the fetch rules.
module tb_c7b_ifu_fetch;

  localparam int          QDEPTH = 4;
  localparam logic [31:0] K      = 32'hC0DE_0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [29:0] redirect_pc;
  logic        ack;
  logic        dv;
  logic [63:0] data;
  logic        ready;

  logic        req,    hi_req;
  logic [28:0] addr,   hi_addr;
  logic        de_valid, hi_valid;
  logic [31:0] de_inst,  hi_inst;
  logic [31:0] de_pc,    hi_pc;

  always #5 clk = ~clk;

  c7b_ifu_fetch #(.RESET_PC(32'h0000_0000), .QDEPTH(QDEPTH)) u_dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ifu_icu_req_ic1(req), .ifu_icu_addr_ic1(addr), .icu_ifu_ack_ic1(ack),
    .icu_ifu_data_valid_ic2(dv), .icu_ifu_data_ic2(data),
    .ifu_de_valid(de_valid), .ifu_de_inst(de_inst), .ifu_de_pc(de_pc), .de_ifu_ready(ready)
  );

  c7b_ifu_fetch #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(QDEPTH)) u_dut_hi (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ifu_icu_req_ic1(hi_req), .ifu_icu_addr_ic1(hi_addr), .icu_ifu_ack_ic1(ack),
    .icu_ifu_data_valid_ic2(dv), .icu_ifu_data_ic2(data),
    .ifu_de_valid(hi_valid), .ifu_de_inst(hi_inst), .ifu_de_pc(hi_pc), .de_ifu_ready(ready)
  );

  // ---------------- scoreboard / model ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] exp_q[$];          // {inst, pc} in decode order
  logic [31:0] m_fetch_pc;
  logic [31:0] m_req_pc;
  bit          m_out;
  bit          m_drop;
  bit          icu_pend;
  int          icu_cnt;
  logic [31:0] icu_line;

  bit          cur_rdr, cur_rdy, cur_ack, cur_dv, cur_mreq;
  logic [29:0] cur_rpc;
  logic [63:0] cur_data;
  logic [31:0] cur_line;
  int          cur_lat;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive one cycle of inputs (called just after negedge) and check outputs.
  task automatic step_drive(input bit rdr, input logic [29:0] rpc, input bit rdy,
                            input bit ack_en, input int lat);
    logic [31:0] junk;
    cur_rdr  = rdr;
    cur_rpc  = rpc;
    cur_rdy  = rdy;
    cur_lat  = lat;
    cur_dv   = icu_pend && (icu_cnt == 0);
    junk     = $urandom();
    cur_data = cur_dv ? {(icu_line + 32'd4) ^ K, icu_line ^ K} : {junk, ~junk};
    cur_mreq = !m_out && ((QDEPTH - exp_q.size()) >= 2) && !rdr;
    cur_ack  = cur_mreq && ack_en;
    cur_line = m_fetch_pc & ~32'h7;
    redirect_valid = rdr;
    redirect_pc    = rpc;
    ready          = rdy;
    ack            = cur_ack;
    dv             = cur_dv;
    data           = cur_data;
    #1;
    chk("req", req, cur_mreq);
    if (cur_mreq) chk("addr", addr, m_fetch_pc[31:3]);
    chk("de_valid", de_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("de_inst", de_inst, exp_q[0][63:32]);
      chk("de_pc",   de_pc,   exp_q[0][31:0]);
    end
  endtask

  // Clock edge, then advance the model by the same cycle.
  task automatic step_clock();
    @(posedge clk);
    if ((exp_q.size() != 0) && cur_rdy) void'(exp_q.pop_front());
    if (cur_rdr) begin
      exp_q.delete();
      if (m_out && cur_dv) begin
        m_out  = 1'b0;
        m_drop = 1'b0;
      end else if (m_out) begin
        m_drop = 1'b1;
      end
      m_fetch_pc = {cur_rpc, 2'b00};
    end else begin
      if (m_out && cur_dv) begin
        if (!m_drop) begin
          if (m_req_pc[2] == 1'b0) begin
            exp_q.push_back({cur_data[31:0], m_req_pc});
            exp_q.push_back({cur_data[63:32], m_req_pc + 32'd4});
          end else begin
            exp_q.push_back({cur_data[63:32], m_req_pc});
          end
        end
        m_out  = 1'b0;
        m_drop = 1'b0;
      end
      if (cur_ack) begin
        m_out      = 1'b1;
        m_req_pc   = m_fetch_pc;
        m_fetch_pc = cur_line + 32'd8;
      end
    end
    if (icu_pend) begin
      if (cur_dv) icu_pend = 1'b0;
      else if (icu_cnt > 0) icu_cnt--;
    end
    if (cur_ack) begin
      icu_pend = 1'b1;
      icu_cnt  = cur_lat - 1;
      icu_line = cur_line;
    end
    @(negedge clk);
  endtask

  task automatic step(input bit rdr, input logic [29:0] rpc, input bit rdy,
                      input bit ack_en, input int lat);
    step_drive(rdr, rpc, rdy, ack_en, lat);
    step_clock();
  endtask

  // Reset both instances; called just after a negedge.
  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    ack = 1'b0; dv = 1'b0; data = '0; ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req",      req,      1'b0);
    chk("rst_de_valid", de_valid, 1'b0);
    chk("rst_de_inst",  de_inst,  32'h0);
    chk("rst_de_pc",    de_pc,    32'h0);
    chk("rst_hi_req",   hi_req,   1'b0);
    chk("rst_hi_valid", hi_valid, 1'b0);
    reset = 1'b0;
    exp_q.delete();
    m_fetch_pc = 32'h0; m_req_pc = '0; m_out = 1'b0; m_drop = 1'b0;
    icu_pend = 1'b0; icu_cnt = 0; icu_line = '0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          rdy;
    bit          ack_en;
    bit          exp_req;
    logic [28:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
    logic [28:0] hi_addr;
    logic [31:0] hi_pc;
  } vec_t;

  vec_t t1 [8];

  initial begin
    logic [31:0] rnd;
    logic [29:0] rpc;

    t1[0] = '{1, 1, 1, 29'h0, 0, 32'h0,  29'h1FFF_FFFF, 32'h0};
    t1[1] = '{1, 1, 0, 29'h0, 0, 32'h0,  29'h0,         32'h0};
    t1[2] = '{1, 1, 1, 29'h1, 1, 32'h0,  29'h0,         32'hFFFF_FFF8};
    t1[3] = '{1, 1, 0, 29'h0, 1, 32'h4,  29'h0,         32'hFFFF_FFFC};
    t1[4] = '{1, 1, 1, 29'h2, 1, 32'h8,  29'h1,         32'h0};
    t1[5] = '{1, 1, 0, 29'h0, 1, 32'hC,  29'h0,         32'h4};
    t1[6] = '{1, 1, 1, 29'h3, 1, 32'h10, 29'h2,         32'h8};
    t1[7] = '{1, 1, 0, 29'h0, 1, 32'h14, 29'h0,         32'hC};

    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    ack = 1'b0; dv = 1'b0; data = '0; ready = 1'b0;
    @(negedge clk);

    // 1/6: hit stream after reset, both reset PCs (including the wrap at the top)
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step_drive(1'b0, '0, t1[i].rdy, t1[i].ack_en, 1);
      chk("t1_req", req, t1[i].exp_req);
      if (t1[i].exp_req) chk("t1_addr", addr, t1[i].exp_addr);
      chk("t1_valid", de_valid, t1[i].exp_valid);
      if (t1[i].exp_valid) chk("t1_pc", de_pc, t1[i].exp_pc);
      chk("t1_hi_valid", hi_valid, t1[i].exp_valid);
      if (t1[i].exp_valid) chk("t1_hi_pc", hi_pc, t1[i].hi_pc);
      if (t1[i].exp_req) chk("t1_hi_addr", hi_addr, t1[i].hi_addr);
      step_clock();
    end
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b1, 1);

    // 2: decode stalled, queue fills to QDEPTH and requests stop
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step_drive(1'b0, '0, 1'b0, 1'b1, 1);
      if (i >= 4) begin
        chk("t2_req_hold", req, 1'b0);
        chk("t2_full_pc", de_pc, 32'h0);
      end
      step_clock();
    end
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b1, 1);

    // 3: redirect to an odd word while IDLE
    do_reset();
    step(1'b1, 30'h41, 1'b1, 1'b1, 1);
    step_drive(1'b0, '0, 1'b1, 1'b1, 1);
    chk("t3_req", req, 1'b1);
    chk("t3_addr", addr, 29'h20);
    step_clock();
    step(1'b0, '0, 1'b1, 1'b1, 1);
    step_drive(1'b0, '0, 1'b1, 1'b1, 1);
    chk("t3_pc0", de_pc, 32'h104);
    chk("t3_inst0", de_inst, 32'h104 ^ K);
    step_clock();
    step(1'b0, '0, 1'b1, 1'b1, 1);
    step_drive(1'b0, '0, 1'b1, 1'b1, 1);
    chk("t3_pc1", de_pc, 32'h108);
    step_clock();
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b1, 1);

    // 4: redirect while a slow miss is outstanding
    do_reset();
    step(1'b0, '0, 1'b1, 1'b1, 6);
    step(1'b1, 30'h80, 1'b1, 1'b1, 1);
    for (int i = 0; i < 5; i++) begin
      step_drive(1'b0, '0, 1'b1, 1'b1, 1);
      chk("t4_empty", de_valid, 1'b0);
      step_clock();
    end
    step_drive(1'b0, '0, 1'b1, 1'b1, 1);
    chk("t4_req", req, 1'b1);
    chk("t4_addr", addr, 29'h40);
    chk("t4_empty_after", de_valid, 1'b0);
    step_clock();
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b1, 1);

    // 5: redirect coinciding with data_valid and a pop
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b1, 1);
    step(1'b1, 30'hC0, 1'b1, 1'b1, 1);
    step_drive(1'b0, '0, 1'b1, 1'b1, 1);
    chk("t5_valid", de_valid, 1'b0);
    chk("t5_req", req, 1'b1);
    chk("t5_addr", addr, 29'h60);
    step_clock();
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b1, 1);

    // 6: reset while WAIT
    do_reset();
    step(1'b0, '0, 1'b1, 1'b1, 3);
    step(1'b0, '0, 1'b1, 1'b1, 1);
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b1, 1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rnd = $urandom();
      rpc = rnd[29:0];
      if ($urandom_range(0, 3) == 0) rpc = 30'h3FFF_FFFC + 30'($urandom_range(0, 3));
      step($urandom_range(0, 19) == 0, rpc, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(1, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
